// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: FSM encodings and the
// field offsets of the divider cores' dout word.
package div_sequencer_pkg;

    typedef enum logic [2:0] {
        DIV_IDLE  = 3'd0,
        DIV_ISSUE = 3'd1,
        DIV_WAIT  = 3'd2,
        DIV_DONE  = 3'd3,
        DIV_DRAIN = 3'd4
    } div_state_e;

    // dout is {quotient, remainder}
    localparam int DOUT_REM_OFS = 0;

    function automatic int dout_quot_ofs(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response handshake between the EXE stage (master) and the
// divide sequencer (slave).
interface div_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_signed;
    logic [DATA_W-1:0] req_dividend;
    logic [DATA_W-1:0] req_divisor;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_quot;
    logic [DATA_W-1:0] resp_rem;

    modport master (
        output req_valid, req_signed, req_dividend, req_divisor, resp_ready,
        input  req_ready, resp_valid, resp_quot, resp_rem
    );

    modport slave (
        input  req_valid, req_signed, req_dividend, req_divisor, resp_ready,
        output req_ready, resp_valid, resp_quot, resp_rem
    );
endinterface

// File: rtl/div_sequencer_axis_src_chan.sv
// One AXI-Stream source channel: tvalid held until its handshake, plus a
// sticky sent flag that the sequencer uses to know the beat has gone.
module axis_src_chan (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tready,
    output logic tvalid,
    output logic done
);
    logic sent;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tvalid <= 1'b0;
            sent   <= 1'b0;
        end else if (start) begin
            tvalid <= 1'b1;
            sent   <= 1'b0;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            sent   <= 1'b1;
        end
    end

    // Counts the handshake cycle itself so ISSUE can leave without a bubble.
    assign done = sent | (tvalid & tready);
endmodule

// File: rtl/div_sequencer.sv
// EXE-stage divide sequencer: owns the signed/unsigned divider cores and
// exposes a single request/response port with flush support.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ZERO_BYPASS = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    div_sequencer_if.slave      bus,
    input  logic                flush,
    output logic                busy,
    output logic                timeout_err,
    output logic [DATA_W-1:0]   dvd_tdata,
    output logic [DATA_W-1:0]   dvs_tdata,
    output logic                s_dvd_tvalid,
    output logic                s_dvs_tvalid,
    input  logic                s_dvd_tready,
    input  logic                s_dvs_tready,
    input  logic                s_dout_tvalid,
    input  logic [2*DATA_W-1:0] s_dout_tdata,
    output logic                u_dvd_tvalid,
    output logic                u_dvs_tvalid,
    input  logic                u_dvd_tready,
    input  logic                u_dvs_tready,
    input  logic                u_dout_tvalid,
    input  logic [2*DATA_W-1:0] u_dout_tdata
);
    localparam int CW   = $clog2(TIMEOUT_CYC + 1);
    localparam int QOFS = dout_quot_ofs(DATA_W);

    div_state_e          state, next;
    logic                sgn, flush_pend;
    logic [CW-1:0]       cnt;
    logic                accept, bypass, start_s, start_u;
    logic                s_dvd_done, s_dvs_done, u_dvd_done, u_dvs_done;
    logic                dvd_done, dvs_done, dout_v;
    logic [2*DATA_W-1:0] dout;

    assign bus.req_ready  = (state == DIV_IDLE) && !flush;
    assign bus.resp_valid = (state == DIV_DONE);
    assign busy           = (state != DIV_IDLE);

    assign accept  = bus.req_valid && bus.req_ready;
    assign bypass  = (ZERO_BYPASS != 0) && (bus.req_divisor == '0);
    assign start_s = accept && !bypass && bus.req_signed;
    assign start_u = accept && !bypass && !bus.req_signed;

    assign dvd_done = sgn ? s_dvd_done : u_dvd_done;
    assign dvs_done = sgn ? s_dvs_done : u_dvs_done;
    assign dout_v   = sgn ? s_dout_tvalid : u_dout_tvalid;
    assign dout     = sgn ? s_dout_tdata : u_dout_tdata;

    axis_src_chan u_s_dvd (.clk(clk), .reset(reset), .start(start_s),
        .tready(s_dvd_tready), .tvalid(s_dvd_tvalid), .done(s_dvd_done));
    axis_src_chan u_s_dvs (.clk(clk), .reset(reset), .start(start_s),
        .tready(s_dvs_tready), .tvalid(s_dvs_tvalid), .done(s_dvs_done));
    axis_src_chan u_u_dvd (.clk(clk), .reset(reset), .start(start_u),
        .tready(u_dvd_tready), .tvalid(u_dvd_tvalid), .done(u_dvd_done));
    axis_src_chan u_u_dvs (.clk(clk), .reset(reset), .start(start_u),
        .tready(u_dvs_tready), .tvalid(u_dvs_tvalid), .done(u_dvs_done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            DIV_IDLE: begin
                if (accept) begin
                    next = bypass ? DIV_DONE : DIV_ISSUE;
                end
            end
            DIV_ISSUE: begin
                // Beats already offered must complete even when flushed.
                if (dvd_done && dvs_done) begin
                    next = (flush_pend || flush) ? DIV_DRAIN : DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (flush) begin
                    next = dout_v ? DIV_IDLE : DIV_DRAIN;
                end else if (dout_v) begin
                    next = DIV_DONE;
                end
            end
            DIV_DRAIN: begin
                if (dout_v) begin
                    next = DIV_IDLE;
                end
            end
            DIV_DONE: begin
                if (flush || bus.resp_ready) begin
                    next = DIV_IDLE;
                end
            end
            default: next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sgn           <= 1'b0;
            flush_pend    <= 1'b0;
            dvd_tdata     <= '0;
            dvs_tdata     <= '0;
            bus.resp_quot <= '0;
            bus.resp_rem  <= '0;
            cnt           <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (accept) begin
                sgn        <= bus.req_signed;
                flush_pend <= 1'b0;
                dvd_tdata  <= bus.req_dividend;
                dvs_tdata  <= bus.req_divisor;
                if (bypass) begin
                    bus.resp_quot <= '0;
                    bus.resp_rem  <= bus.req_dividend;
                end
            end
            if (state == DIV_ISSUE && flush) begin
                flush_pend <= 1'b1;
            end
            if (state == DIV_WAIT && dout_v && !flush) begin
                bus.resp_quot <= dout[QOFS +: DATA_W];
                bus.resp_rem  <= dout[DOUT_REM_OFS +: DATA_W];
            end
            if (state != DIV_WAIT) begin
                cnt <= '0;
            end else if (cnt != CW'(TIMEOUT_CYC - 1)) begin
                cnt <= cnt + 1'b1;
            end else begin
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer with hand-computed expectations.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        busy, timeout_err;
    logic [31:0] dvd_tdata, dvs_tdata;
    logic        s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid;
    logic        s_dvd_tready = 0, s_dvs_tready = 0, s_dout_tvalid = 0;
    logic        u_dvd_tready = 0, u_dvs_tready = 0, u_dout_tvalid = 0;
    logic [63:0] s_dout_tdata = '0, u_dout_tdata = '0;

    int n_tests = 0;
    int n_fail = 0;
    int c_sdvd = 0, c_sdvs = 0, c_udvd = 0, c_udvs = 0, c_resp = 0;

    div_sequencer_if #(.DATA_W(32)) bus ();

    div_sequencer #(.DATA_W(32), .ZERO_BYPASS(1), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .bus(bus), .flush(flush),
        .busy(busy), .timeout_err(timeout_err),
        .dvd_tdata(dvd_tdata), .dvs_tdata(dvs_tdata),
        .s_dvd_tvalid(s_dvd_tvalid), .s_dvs_tvalid(s_dvs_tvalid),
        .s_dvd_tready(s_dvd_tready), .s_dvs_tready(s_dvs_tready),
        .s_dout_tvalid(s_dout_tvalid), .s_dout_tdata(s_dout_tdata),
        .u_dvd_tvalid(u_dvd_tvalid), .u_dvs_tvalid(u_dvs_tvalid),
        .u_dvd_tready(u_dvd_tready), .u_dvs_tready(u_dvs_tready),
        .u_dout_tvalid(u_dout_tvalid), .u_dout_tdata(u_dout_tdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s_dvd_tvalid) c_sdvd++;
        if (s_dvs_tvalid) c_sdvs++;
        if (u_dvd_tvalid) c_udvd++;
        if (u_dvs_tvalid) c_udvs++;
        if (bus.resp_valid) c_resp++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_req(input logic sg, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid    = 1'b1;
        bus.req_signed   = sg;
        bus.req_dividend = a;
        bus.req_divisor  = b;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b resp_valid=%b tmo=%b want 0 0 0",
                     busy, bus.resp_valid, timeout_err);
        end
        n_tests++;
        if ({s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_tvalid: got %b want 0000",
                     {s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid});
        end
        n_tests++;
        if (bus.resp_quot !== 32'h0 || bus.resp_rem !== 32'h0 ||
            dvd_tdata !== 32'h0 || dvs_tdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: q=%h r=%h dvd=%h dvs=%h want all 0",
                     bus.resp_quot, bus.resp_rem, dvd_tdata, dvs_tdata);
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_signed();
        int u0, u1;
        u0 = c_udvd;
        u1 = c_udvs;
        s_dvd_tready = 1'b1;
        s_dvs_tready = 1'b1;
        u_dout_tvalid = 1'b1;
        u_dout_tdata = 64'hDEAD_BEEF_CAFE_F00D;
        put_req(1'b1, 32'hFFFF_FFF9, 32'd2);
        n_tests++;
        if (s_dvd_tvalid !== 1'b1 || s_dvs_tvalid !== 1'b1 || dvd_tdata !== 32'hFFFF_FFF9) begin
            n_fail++;
            $display("FAIL signed_issue: tv=%b%b dvd=%h want 11 fffffff9",
                     s_dvd_tvalid, s_dvs_tvalid, dvd_tdata);
        end
        step();
        n_tests++;
        if (s_dvd_tvalid !== 1'b0 || s_dvs_tvalid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL signed_wait: tv=%b%b busy=%b want 00 1",
                     s_dvd_tvalid, s_dvs_tvalid, busy);
        end
        for (int i = 0; i < 9; i++) step();
        s_dout_tvalid = 1'b1;
        s_dout_tdata = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
        step();
        s_dout_tvalid = 1'b0;
        u_dout_tvalid = 1'b0;
        n_tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_quot !== 32'hFFFF_FFFD ||
            bus.resp_rem !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL signed_result: v=%b q=%h r=%h want 1 fffffffd ffffffff",
                     bus.resp_valid, bus.resp_quot, bus.resp_rem);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || c_udvd != u0 || c_udvs != u1) begin
            n_fail++;
            $display("FAIL signed_u_idle: busy=%b u_cycles=%0d want 0 0",
                     busy, (c_udvd - u0) + (c_udvs - u1));
        end
        s_dvd_tready = 1'b0;
        s_dvs_tready = 1'b0;
    endtask

    task automatic test_unsigned_stagger();
        int d0, v0;
        d0 = c_udvd;
        v0 = c_udvs;
        u_dvd_tready = 1'b0;
        u_dvs_tready = 1'b1;
        put_req(1'b0, 32'hFFFF_FFFF, 32'd16);
        step();
        step();
        step();
        u_dvd_tready = 1'b1;
        step();
        u_dvd_tready = 1'b0;
        n_tests++;
        if (c_udvd - d0 != 4 || c_udvs - v0 != 1) begin
            n_fail++;
            $display("FAIL stagger_cycles: dvd=%0d dvs=%0d want 4 1",
                     c_udvd - d0, c_udvs - v0);
        end
        n_tests++;
        if (busy !== 1'b1 || u_dvd_tvalid !== 1'b0 || u_dvs_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stagger_wait: busy=%b tv=%b%b want 1 00",
                     busy, u_dvd_tvalid, u_dvs_tvalid);
        end
        u_dout_tvalid = 1'b1;
        u_dout_tdata = {32'h0FFF_FFFF, 32'h0000_000F};
        step();
        u_dout_tvalid = 1'b0;
        n_tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_quot !== 32'h0FFF_FFFF ||
            bus.resp_rem !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL unsigned_result: v=%b q=%h r=%h want 1 0fffffff 0000000f",
                     bus.resp_valid, bus.resp_quot, bus.resp_rem);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        u_dvs_tready = 1'b0;
    endtask

    task automatic test_zero_bypass();
        int t0;
        t0 = c_sdvd + c_sdvs + c_udvd + c_udvs;
        put_req(1'b1, 32'h0000_1234, 32'd0);
        n_tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_quot !== 32'h0 || bus.resp_rem !== 32'h1234) begin
            n_fail++;
            $display("FAIL zero_result: v=%b q=%h r=%h want 1 0 1234",
                     bus.resp_valid, bus.resp_quot, bus.resp_rem);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        n_tests++;
        if (c_sdvd + c_sdvs + c_udvd + c_udvs != t0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_tvalid: cycles=%0d busy=%b want 0 0",
                     c_sdvd + c_sdvs + c_udvd + c_udvs - t0, busy);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        put_req(1'b0, 32'h0000_0055, 32'd0);
        bus.req_valid = 1'b1;
        bus.req_divisor = 32'd3;
        bus.req_dividend = 32'h77;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_quot !== 32'h0 ||
                bus.resp_rem !== 32'h55 || bus.req_ready !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: unstable cycles=%0d want 0", bad);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_no_accept: busy=%b v=%b want 0 0", busy, bus.resp_valid);
        end
    endtask

    task automatic test_flush_wait();
        int r0;
        s_dvd_tready = 1'b1;
        s_dvs_tready = 1'b1;
        put_req(1'b1, 32'd100, 32'd7);
        step();
        s_dvd_tready = 1'b0;
        s_dvs_tready = 1'b0;
        r0 = c_resp;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) step();
        s_dout_tvalid = 1'b1;
        s_dout_tdata = {32'd14, 32'd2};
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_busy: got %b want 1", busy);
        end
        step();
        s_dout_tvalid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || c_resp != r0) begin
            n_fail++;
            $display("FAIL flush_wait: busy=%b resp_cycles=%0d want 0 0", busy, c_resp - r0);
        end
        u_dvd_tready = 1'b1;
        u_dvs_tready = 1'b1;
        put_req(1'b0, 32'd100, 32'd7);
        step();
        u_dvd_tready = 1'b0;
        u_dvs_tready = 1'b0;
        u_dout_tvalid = 1'b1;
        u_dout_tdata = {32'd14, 32'd2};
        step();
        u_dout_tvalid = 1'b0;
        n_tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_quot !== 32'd14 || bus.resp_rem !== 32'd2) begin
            n_fail++;
            $display("FAIL after_flush: v=%b q=%h r=%h want 1 e 2",
                     bus.resp_valid, bus.resp_quot, bus.resp_rem);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_flush_issue();
        int bad;
        bad = 0;
        s_dvd_tready = 1'b1;
        put_req(1'b1, 32'd50, 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        s_dvd_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (s_dvs_tvalid !== 1'b1 || s_dvd_tvalid !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL flush_issue_hold: bad cycles=%0d want 0", bad);
        end
        s_dvs_tready = 1'b1;
        step();
        s_dvs_tready = 1'b0;
        n_tests++;
        if (s_dvs_tvalid !== 1'b0 || busy !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_issue_drain: tv=%b busy=%b v=%b want 0 1 0",
                     s_dvs_tvalid, busy, bus.resp_valid);
        end
        s_dout_tvalid = 1'b1;
        step();
        s_dout_tvalid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_issue_idle: busy=%b v=%b want 0 0", busy, bus.resp_valid);
        end
    endtask

    task automatic test_flush_done();
        put_req(1'b0, 32'h99, 32'd0);
        flush = 1'b1;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: busy=%b v=%b want 0 0", busy, bus.resp_valid);
        end
        bus.req_valid = 1'b1;
        bus.req_divisor = 32'd0;
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_ready: got %b want 0", bus.req_ready);
        end
        step();
        bus.req_valid = 1'b0;
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_accept: busy=%b want 0", busy);
        end
    endtask

    task automatic test_timeout_reset();
        s_dvd_tready = 1'b1;
        s_dvs_tready = 1'b1;
        put_req(1'b1, 32'hABCD, 32'd3);
        step();
        s_dvd_tready = 1'b0;
        s_dvs_tready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got %b want 0", timeout_err);
        end
        for (int i = 0; i < 60; i++) step();
        n_tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_set: tmo=%b busy=%b want 1 1", timeout_err, busy);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b0 || bus.resp_valid !== 1'b0 ||
            dvd_tdata !== 32'h0 || dvs_tdata !== 32'h0 ||
            {s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid} !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset: tmo=%b busy=%b v=%b dvd=%h dvs=%h want all 0",
                     timeout_err, busy, bus.resp_valid, dvd_tdata, dvs_tdata);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_signed();
        test_unsigned_stagger();
        test_zero_bypass();
        test_backpressure();
        test_flush_wait();
        test_flush_issue();
        test_flush_done();
        test_timeout_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller in the EXE stage that owns the signed and unsigned divider IP cores.
- Accepts one divide request at a time over a valid/ready port and latches its operands.
- Drives each core's divisor and dividend AXI-Stream channels independently, waits for dout, and returns quotient/remainder over a valid/ready response port.
- Handles pipeline flush without violating AXI-Stream rules. Removes all divider handshake logic from the stage itself.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W.
- ZERO_BYPASS, 1, when 1 a zero divisor skips the cores and returns a fixed result.
- TIMEOUT_CYC, 64, WAIT cycles before timeout_err asserts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  EXE stage has a div/divu to issue
- req_ready  out  1  sequencer can accept a request
- req_signed  in  1  1 = div, 0 = divu
- req_dividend  in  DATA_W  rs value
- req_divisor  in  DATA_W  rt value
- flush  in  1  cancel the current operation (exception/eret)
- resp_valid  out  1  result available
- resp_ready  in  1  EXE stage consumes the result
- resp_quot  out  DATA_W  quotient (to LO)
- resp_rem  out  DATA_W  remainder (to HI)
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; WAIT exceeded TIMEOUT_CYC
- dvd_tdata  out  DATA_W  latched dividend, shared by both cores
- dvs_tdata  out  DATA_W  latched divisor, shared by both cores
- s_dvd_tvalid/s_dvs_tvalid  out  1 each  signed core input valids
- s_dvd_tready/s_dvs_tready  in  1 each  signed core input readies
- s_dout_tvalid  in  1; s_dout_tdata  in  2*DATA_W  signed core output
- u_dvd_tvalid/u_dvs_tvalid  out  1 each; u_dvd_tready/u_dvs_tready  in  1 each; u_dout_tvalid  in  1; u_dout_tdata  in  2*DATA_W  unsigned core equivalents

Behaviour:
- Reset (async, active-high): state IDLE; all tvalid 0; resp_valid 0; resp_quot/resp_rem 0; timeout_err 0; busy 0; operand regs 0.
- dout layout: [2*DATA_W-1:DATA_W] quotient, [DATA_W-1:0] remainder.
- req_ready = (state==IDLE) && !flush. A request is accepted when req_valid && req_ready; at acceptance, operands and the signed flag are latched. tdata is always driven from the latched registers, never from the request ports.
- IDLE -> ISSUE on accept when the divisor is nonzero, or when ZERO_BYPASS=0.
- IDLE -> DONE on accept when ZERO_BYPASS=1 and the divisor is 0. Result is quot=0, rem=dividend; resp_valid rises the next cycle.
- ISSUE (only the selected core's valids are driven):
  - Both tvalids are high on entry.
  - Each channel keeps its own "sent" flag. Its tvalid drops in the cycle after its own tvalid&&tready.
  - Once asserted, a tvalid never drops before its handshake.
  - When both flags are set, go to WAIT. If both handshakes occur in the same cycle, WAIT is entered the next cycle.
  - Minimum accept-to-WAIT is 2 cycles.
- WAIT: capture dout when the selected core's dout_tvalid is high, then go to DONE. The other core's dout is ignored. A cycle counter runs; when it reaches TIMEOUT_CYC, timeout_err is set (sticky until reset) and the FSM stays in WAIT.
- DONE: resp_valid=1; quot/rem stable. Go to IDLE in the same cycle as resp_ready. A new request is not accepted in that cycle.
- flush by state:
  - IDLE: no accept.
  - ISSUE: pending tvalids stay up until their handshakes complete, then go to DRAIN.
  - WAIT: go to DRAIN, or straight to IDLE if dout_tvalid is high that same cycle (dout discarded).
  - DRAIN: wait for the selected dout_tvalid, discard it, go to IDLE. resp_valid stays 0.
  - DONE: resp_valid drops and the FSM goes to IDLE the next cycle.
- Simultaneous flush and resp_ready in DONE: treated as a flush; the response is not consumed.
- Simultaneous flush and req_valid in IDLE: the request is not accepted.
- The EXE stage derives es_ready_go = resp_valid for div ops and writes HI/LO from resp_rem/resp_quot on the resp handshake.

Decomposition:
- Shared package (mycpu.h):
  - state encodings: DIV_IDLE=0, DIV_ISSUE=1, DIV_WAIT=2, DIV_DONE=3, DIV_DRAIN=4 (3-bit);
  - the dout quotient/remainder field offsets.
- One sub-module, axis_src_chan: a tvalid/sent-flag pair with start, tready, and done.
  - Four instances: s/u × dividend/divisor.
  - Only the selected core's pair is started.

Test Plan:
- Signed: req_signed=1, dividend 0xFFFFFFF9 (-7), divisor 2, core returns after 10 cycles -> resp_quot 0xFFFFFFFD, resp_rem 0xFFFFFFFF; u_* tvalids never rise.
- Unsigned with staggered readies: 0xFFFFFFFF / 16; dvd_tready delayed 3 cycles, dvs_tready immediate -> s_/u_dvs_tvalid high exactly 1 cycle, dvd_tvalid 4 cycles; result quot 0x0FFFFFFF, rem 0xF.
- Zero divisor: 0x1234 / 0 with ZERO_BYPASS=1 -> no tvalid ever high; resp_valid 1 cycle after accept; quot 0, rem 0x1234.
- Flush cases:
  - flush during WAIT, dout arrives 5 cycles later -> state DRAIN, resp_valid never rises, IDLE the cycle after dout, next request accepted and correct.
  - flush during ISSUE with dvs_tready held low -> dvs_tvalid stays high until its handshake; no early drop.
- Backpressure: resp_ready low for 6 cycles in DONE -> resp_valid/quot/rem stable, req_ready 0; reset asserted mid-WAIT -> all outputs 0 immediately.
